geofence_ctrl: RTL and testbench

Sequencer for the geofence decision datapath. It captures one target point and six unordered fence points from the `X`/`Y` stream. It then sorts the fence points counter-clockwise by issuing comparisons to an external shared cross-product unit over a req/ack handshake, and runs the six edge-side tests against the target through the same unit. It sits between the coordinate input port and the cross-product datapath and produces the final `valid`/`is_inside` result.

---
 rtl/geofence_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_geofence_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_ctrl.sv
// geofence_ctrl -- sequencer for the geofence decision datapath.
//
// Captures one target point T and six fence points P[0..5] from the X/Y
// stream, sorts P[1..5] counter-clockwise about the anchor P[0] with a fixed
// 16-compare bubble sort, then runs six edge-side tests of T against the
// sorted polygon. Every orientation decision is delegated to an external
// shared cross-product unit over a req/ack handshake.
//
// Optional feature macro: GEOFENCE_CTRL_EARLY_EXIT_EN
//   defined   : TEST stops at the first failing edge and goes straight to DONE.
//   undefined : all six TEST transactions are always issued (fixed latency).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   X, Y       in   10-bit unsigned coordinates, sampled in LOAD
//   cp_req     out  cross-product request; operands valid while high
//   cp_ax/ay   out  11-bit signed vector A
//   cp_bx/by   out  11-bit signed vector B
//   cp_ack     in   datapath result valid this cycle
//   cp_neg     in   Ax*By - Ay*Bx < 0 (qualified by cp_ack)
//   cp_zero    in   Ax*By - Ay*Bx == 0 (qualified by cp_ack)
//   valid      out  one-cycle result strobe
//   is_inside  out  result, meaningful only while valid is high
module geofence_ctrl (
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         X,
  input  logic [9:0]         Y,
  output logic               cp_req,
  output logic signed [10:0] cp_ax,
  output logic signed [10:0] cp_ay,
  output logic signed [10:0] cp_bx,
  output logic signed [10:0] cp_by,
  input  logic               cp_ack,
  input  logic               cp_neg,
  input  logic               cp_zero,
  output logic               valid,
  output logic               is_inside
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_TEST,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [2:0]  r_load_cnt;   // sample index 0..6 within LOAD
  logic [3:0]  r_cmp_cnt;    // sort transaction 0..15
  logic [2:0]  r_test_idx;   // edge index 0..5
  logic        r_all_pass;

  logic [9:0]  r_tx;
  logic [9:0]  r_ty;
  logic [9:0]  w_px [0:5];
  logic [9:0]  w_py [0:5];

  logic        w_busy;
  logic        w_fire;
  logic        w_swap;
  logic        w_edge_fail;
  logic        w_test_end;
  logic [2:0]  w_k;
  logic [2:0]  w_k1;
  logic [2:0]  w_tnext;
  logic [9:0]  w_pkx;
  logic [9:0]  w_pky;
  logic [9:0]  w_pk1x;
  logic [9:0]  w_pk1y;

  // Zero-extended subtraction: two 10-bit unsigned values always fit an
  // 11-bit signed difference.
  function automatic logic signed [10:0] f_diff(input logic [9:0] a, input logic [9:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // A request is outstanding in every SORT and TEST cycle; the handshake
  // completes on any edge where ack is also high.
  assign w_busy      = (r_state == S_SORT) | (r_state == S_TEST);
  assign cp_req      = w_busy;
  assign w_fire      = w_busy & cp_ack;
  assign w_edge_fail = cp_neg | cp_zero;

  // Sort compare k walks 1..4 within each pass; the low two bits of the
  // transaction counter give the position, so passes need no separate count.
  assign w_k     = 3'd1 + {1'b0, r_cmp_cnt[1:0]};
  assign w_k1    = w_k + 3'd1;
  assign w_tnext = (r_test_idx == 3'd5) ? 3'd0 : r_test_idx + 3'd1;

  assign w_pkx  = w_px[w_k];
  assign w_pky  = w_py[w_k];
  assign w_pk1x = w_px[w_k1];
  assign w_pk1y = w_py[w_k1];

  // A negative cross product means P[k+1] lies clockwise of P[k] about P[0].
  assign w_swap = (r_state == S_SORT) & w_fire & cp_neg;

`ifdef GEOFENCE_CTRL_EARLY_EXIT_EN
  assign w_test_end = (r_test_idx == 3'd5) | w_edge_fail;
`else
  assign w_test_end = (r_test_idx == 3'd5);
`endif

  // Fence point registers: each slot loads its own LOAD sample and takes
  // part in a swap when it is either side of the current compare.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_pt
      logic [9:0] r_x;
      logic [9:0] r_y;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_x <= '0;
          r_y <= '0;
        end else if ((r_state == S_LOAD) && (r_load_cnt == 3'(gi + 1))) begin
          r_x <= X;
          r_y <= Y;
        end else if (w_swap && (w_k == 3'(gi))) begin
          r_x <= w_pk1x;
          r_y <= w_pk1y;
        end else if (w_swap && (w_k1 == 3'(gi))) begin
          r_x <= w_pkx;
          r_y <= w_pky;
        end
      end

      assign w_px[gi] = r_x;
      assign w_py[gi] = r_y;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx <= '0;
      r_ty <= '0;
    end else if ((r_state == S_LOAD) && (r_load_cnt == 3'd0)) begin
      r_tx <= X;
      r_ty <= Y;
    end
  end

  // Sequencing counters and the running pass flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_cnt <= '0;
      r_cmp_cnt  <= '0;
      r_test_idx <= '0;
      r_all_pass <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_load_cnt <= (r_load_cnt == 3'd6) ? 3'd0 : r_load_cnt + 3'd1;
          r_cmp_cnt  <= '0;
          r_test_idx <= '0;
          r_all_pass <= 1'b1;
        end
        S_SORT: begin
          if (w_fire) begin
            r_cmp_cnt <= r_cmp_cnt + 4'd1;
          end
        end
        S_TEST: begin
          if (w_fire) begin
            r_test_idx <= w_tnext;
            if (w_edge_fail) begin
              r_all_pass <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and datapath operands. Operands are a pure function of the
  // registered state, so they stay stable for as long as ack is withheld.
  always_comb begin
    w_state_next = r_state;
    cp_ax        = '0;
    cp_ay        = '0;
    cp_bx        = '0;
    cp_by        = '0;
    valid        = 1'b0;
    is_inside    = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (r_load_cnt == 3'd6) begin
          w_state_next = S_SORT;
        end
      end
      S_SORT: begin
        cp_ax = f_diff(w_pkx, w_px[0]);
        cp_ay = f_diff(w_pky, w_py[0]);
        cp_bx = f_diff(w_pk1x, w_px[0]);
        cp_by = f_diff(w_pk1y, w_py[0]);
        if (w_fire && (r_cmp_cnt == 4'd15)) begin
          w_state_next = S_TEST;
        end
      end
      S_TEST: begin
        cp_ax = f_diff(w_px[r_test_idx], r_tx);
        cp_ay = f_diff(w_py[r_test_idx], r_ty);
        cp_bx = f_diff(w_px[w_tnext], r_tx);
        cp_by = f_diff(w_py[w_tnext], r_ty);
        if (w_fire && w_test_end) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        valid        = 1'b1;
        is_inside    = r_all_pass;
        w_state_next = S_LOAD;
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_geofence_ctrl.sv
// Testbench for geofence_ctrl: acts as the cross-product datapath (with an
// optional ack delay), drives point sets and compares every result against a
// convex-hull reference model computed from the raw, unsorted points.
module tb_geofence_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic [9:0]         X;
  logic [9:0]         Y;
  logic               cp_req;
  logic signed [10:0] cp_ax;
  logic signed [10:0] cp_ay;
  logic signed [10:0] cp_bx;
  logic signed [10:0] cp_by;
  logic               cp_ack;
  logic               cp_neg;
  logic               cp_zero;
  logic               valid;
  logic               is_inside;

  geofence_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .Y         (Y),
    .cp_req    (cp_req),
    .cp_ax     (cp_ax),
    .cp_ay     (cp_ay),
    .cp_bx     (cp_bx),
    .cp_by     (cp_by),
    .cp_ack    (cp_ack),
    .cp_neg    (cp_neg),
    .cp_zero   (cp_zero),
    .valid     (valid),
    .is_inside (is_inside)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  int fx[6] = '{300, 150, 250, 100, 250, 150};
  int fy[6] = '{200, 113, 287, 200, 113, 287};

  // Edge counter: after edge n has happened, edges holds n+1 relative to 0.
  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  // Cross-product datapath model with configurable ack latency.
  bit ack_tied  = 1'b1;
  int ack_delay = 0;
  int wait_cnt  = 0;
  int cross_v;

  always @(posedge clk) begin
    if (cp_req && !cp_ack) wait_cnt <= wait_cnt + 1;
    else                   wait_cnt <= 0;
  end

  assign cp_ack = ack_tied ? 1'b1 : (cp_req && (wait_cnt >= ack_delay));

  always_comb begin
    cross_v = int'(cp_ax) * int'(cp_by) - int'(cp_ay) * int'(cp_bx);
  end

  assign cp_neg  = (cross_v < 0);
  assign cp_zero = (cross_v == 0);

  // Monitor, sampled mid-cycle on the falling edge.
  int          vcyc_q[$];
  bit          vval_q[$];
  int          trans_cnt = 0;
  int          zero_cnt  = 0;
  int          stab_err  = 0;
  int          seq_idx   = 0;
  bit          prev_wait = 1'b0;
  logic [43:0] prev_ops  = '0;

  always @(negedge clk) begin
    if (prev_wait && (!cp_req || ({cp_ax, cp_ay, cp_bx, cp_by} != prev_ops))) stab_err++;
    prev_wait = cp_req && !cp_ack && !reset;
    prev_ops  = {cp_ax, cp_ay, cp_bx, cp_by};
    if (valid) begin
      vcyc_q.push_back(edges + 1);
      vval_q.push_back(is_inside);
    end
    if (!cp_req) begin
      seq_idx = 0;
    end else if (cp_ack && !reset) begin
      if (seq_idx >= 16 && cp_zero) zero_cnt++;
      seq_idx++;
      trans_cnt++;
    end
  end

  // Reference: T is inside iff it lies strictly left of every CCW hull edge.
  // Hull edges are found directly as ordered pairs with all other points
  // strictly to their left, so no sorting is involved.
  function automatic bit model_inside(input int tx, input int ty, input int px[6], input int py[6]);
    int  n_edges;
    bit  ok;
    bit  hull;
    int  c;
    n_edges = 0;
    ok      = 1'b1;
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        if (i != j) begin
          hull = 1'b1;
          for (int k = 0; k < 6; k++) begin
            if (k != i && k != j) begin
              c = (px[j] - px[i]) * (py[k] - py[i]) - (py[j] - py[i]) * (px[k] - px[i]);
              if (c <= 0) hull = 1'b0;
            end
          end
          if (hull) begin
            n_edges++;
            c = (px[j] - px[i]) * (ty - py[i]) - (py[j] - py[i]) * (tx - px[i]);
            if (c <= 0) ok = 1'b0;
          end
        end
      end
    end
    return ok && (n_edges >= 3);
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load_points(input int tx, input int ty, input int px[6], input int py[6]);
    X = 10'(tx);
    Y = 10'(ty);
    @(posedge clk); #1;
    for (int s = 0; s < 6; s++) begin
      X = 10'(px[s]);
      Y = 10'(py[s]);
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_valid(input int n0, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (vcyc_q.size() > n0) break;
      @(posedge clk); #1;
    end
    got = (vcyc_q.size() > n0);
  endtask

  task automatic run_set(input bit rst_first, input int tx, input int ty,
                         input int px[6], input int py[6],
                         output bit got, output int rel, output bit vin,
                         output int ntr, output int nz, output int nst);
    int base, n0, t0, z0, s0;
    if (rst_first) do_reset();
    n0   = vcyc_q.size();
    t0   = trans_cnt;
    z0   = zero_cnt;
    s0   = stab_err;
    base = edges + 1;
    load_points(tx, ty, px, py);
    wait_valid(n0, 400, got);
    rel = got ? (vcyc_q[n0] - base) : -1;
    vin = got ? vval_q[n0] : 1'b0;
    ntr = trans_cnt - t0;
    nz  = zero_cnt - z0;
    nst = stab_err - s0;
    $display("[TB] set T=(%0d,%0d) got=%0b is_inside=%0b valid_cycle=%0d transactions=%0d",
             tx, ty, got, vin, rel, ntr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    X = '0;
    Y = '0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (cp_req !== 1'b0) begin
      tests_failed++; $display("FAIL reset_cp_req got=%0b exp=0", cp_req);
    end
    tests_run++;
    if (valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valid got=%0b exp=0", valid);
    end
    tests_run++;
    if (is_inside !== 1'b0) begin
      tests_failed++; $display("FAIL reset_is_inside got=%0b exp=0", is_inside);
    end
    tests_run++;
    if ({cp_ax, cp_ay, cp_bx, cp_by} !== 44'd0) begin
      tests_failed++; $display("FAIL reset_operands got=%h exp=0", {cp_ax, cp_ay, cp_bx, cp_by});
    end
  endtask

  task automatic test_spec_inside();
    bit got, vin; int rel, ntr, nz, nst;
    ack_tied = 1'b1;
    run_set(1'b1, 200, 200, fx, fy, got, rel, vin, ntr, nz, nst);
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL inside_timeout got=no_valid exp=valid"); end
    tests_run++;
    if (rel !== 29) begin tests_failed++; $display("FAIL inside_latency got=%0d exp=29", rel); end
    tests_run++;
    if (vin !== 1'b1) begin tests_failed++; $display("FAIL inside_result got=%0b exp=1", vin); end
    tests_run++;
    if (ntr !== 22) begin tests_failed++; $display("FAIL inside_requests got=%0d exp=22", ntr); end
  endtask

  task automatic test_spec_outside();
    bit got, vin; int rel, ntr, nz, nst;
    ack_tied = 1'b1;
    run_set(1'b1, 400, 400, fx, fy, got, rel, vin, ntr, nz, nst);
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL outside_timeout got=no_valid exp=valid"); end
    tests_run++;
    if (vin !== 1'b0) begin tests_failed++; $display("FAIL outside_result got=%0b exp=0", vin); end
`ifdef GEOFENCE_CTRL_EARLY_EXIT_EN
    tests_run++;
    if (!(rel >= 0 && rel < 29)) begin tests_failed++; $display("FAIL outside_latency got=%0d exp=<29", rel); end
    tests_run++;
    if (!(ntr >= 17 && ntr < 22)) begin tests_failed++; $display("FAIL outside_requests got=%0d exp=17..21", ntr); end
`else
    tests_run++;
    if (rel !== 29) begin tests_failed++; $display("FAIL outside_latency got=%0d exp=29", rel); end
    tests_run++;
    if (ntr !== 22) begin tests_failed++; $display("FAIL outside_requests got=%0d exp=22", ntr); end
`endif
  endtask

  task automatic test_vertex();
    bit got, vin; int rel, ntr, nz, nst;
    ack_tied = 1'b1;
    run_set(1'b1, 300, 200, fx, fy, got, rel, vin, ntr, nz, nst);
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL vertex_timeout got=no_valid exp=valid"); end
    tests_run++;
    if (nz < 1) begin tests_failed++; $display("FAIL vertex_zero_seen got=%0d exp=>=1", nz); end
    tests_run++;
    if (vin !== 1'b0) begin tests_failed++; $display("FAIL vertex_result got=%0b exp=0", vin); end
  endtask

  task automatic test_ack_delay();
    bit got, vin; int rel, ntr, nz, nst;
    ack_tied  = 1'b0;
    ack_delay = 3;
    run_set(1'b1, 200, 200, fx, fy, got, rel, vin, ntr, nz, nst);
    ack_tied  = 1'b1;
    tests_run++;
    if (!got) begin tests_failed++; $display("FAIL delay_timeout got=no_valid exp=valid"); end
    tests_run++;
    if (rel !== 95) begin tests_failed++; $display("FAIL delay_latency got=%0d exp=95", rel); end
    tests_run++;
    if (vin !== 1'b1) begin tests_failed++; $display("FAIL delay_result got=%0b exp=1", vin); end
    tests_run++;
    if (nst !== 0) begin tests_failed++; $display("FAIL delay_operand_stability got=%0d exp=0", nst); end
  endtask

  task automatic test_reset_mid_sort();
    bit got;
    int n0, base2;
    ack_tied = 1'b1;
    do_reset();
    n0 = vcyc_q.size();
    load_points(400, 400, fx, fy);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (cp_req !== 1'b0) begin tests_failed++; $display("FAIL midreset_cp_req got=%0b exp=0", cp_req); end
    base2 = edges + 1;
    load_points(200, 200, fx, fy);
    wait_valid(n0, 400, got);
    $display("[TB] set after mid-sort reset got=%0b", got);
    tests_run++;
    if (!got) begin
      tests_failed++; $display("FAIL midreset_timeout got=no_valid exp=valid");
    end else begin
      tests_run++;
      if (vcyc_q.size() !== n0 + 1) begin
        tests_failed++; $display("FAIL midreset_pulses got=%0d exp=1", vcyc_q.size() - n0);
      end
      tests_run++;
      if (vcyc_q[n0] - base2 !== 29) begin
        tests_failed++; $display("FAIL midreset_latency got=%0d exp=29", vcyc_q[n0] - base2);
      end
      tests_run++;
      if (vval_q[n0] !== 1'b1) begin
        tests_failed++; $display("FAIL midreset_result got=%0b exp=1", vval_q[n0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit got1, got2, vin1, vin2; int rel, ntr, nz, nst, n0;
    ack_tied = 1'b1;
    do_reset();
    n0 = vcyc_q.size();
    run_set(1'b0, 200, 200, fx, fy, got1, rel, vin1, ntr, nz, nst);
    run_set(1'b0, 400, 400, fx, fy, got2, rel, vin2, ntr, nz, nst);
    tests_run++;
    if (!(got1 && got2)) begin
      tests_failed++; $display("FAIL b2b_timeout got=%0b%0b exp=11", got1, got2);
    end else begin
      tests_run++;
      if (vcyc_q.size() !== n0 + 2) begin
        tests_failed++; $display("FAIL b2b_pulses got=%0d exp=2", vcyc_q.size() - n0);
      end
      tests_run++;
      if (vcyc_q[n0 + 1] - vcyc_q[n0] !== 30) begin
        tests_failed++; $display("FAIL b2b_spacing got=%0d exp=30", vcyc_q[n0 + 1] - vcyc_q[n0]);
      end
      tests_run++;
      if ({vin1, vin2} !== 2'b10) begin
        tests_failed++; $display("FAIL b2b_results got=%0b%0b exp=10", vin1, vin2);
      end
    end
  endtask

  task automatic test_random();
    bit got, vin, expv; int rel, ntr, nz, nst, d;
    int px[6]; int py[6];
    int cx, cy, r, base_ang, jit, k, tmp, tx, ty, mode;
    real ang;
    for (int it = 0; it < 40; it++) begin
      cx       = int'($urandom_range(250, 770));
      cy       = int'($urandom_range(250, 770));
      r        = int'($urandom_range(80, 200));
      base_ang = int'($urandom_range(0, 359));
      for (int j = 0; j < 6; j++) begin
        jit   = int'($urandom_range(0, 30)) - 15;
        ang   = real'(base_ang + 60 * j + jit) * 3.14159265358979 / 180.0;
        px[j] = int'(real'(cx) + real'(r) * $cos(ang));
        py[j] = int'(real'(cy) + real'(r) * $sin(ang));
      end
      for (int j = 5; j > 0; j--) begin
        k = int'($urandom_range(0, j));
        tmp = px[j]; px[j] = px[k]; px[k] = tmp;
        tmp = py[j]; py[j] = py[k]; py[k] = tmp;
      end
      mode = int'($urandom_range(0, 3));
      if (mode <= 1) begin
        tx = cx + int'($urandom_range(0, 2 * (r / 3))) - r / 3;
        ty = cy + int'($urandom_range(0, 2 * (r / 3))) - r / 3;
      end else if (mode == 2) begin
        tx = int'($urandom_range(0, 1023));
        ty = int'($urandom_range(0, 1023));
      end else begin
        k  = int'($urandom_range(0, 5));
        tx = px[k];
        ty = py[k];
      end
      ack_tied  = ($urandom_range(0, 1) == 0);
      ack_delay = int'($urandom_range(0, 3));
      d         = ack_tied ? 0 : ack_delay;
      expv      = model_inside(tx, ty, px, py);
      run_set(1'b1, tx, ty, px, py, got, rel, vin, ntr, nz, nst);
      tests_run++;
      if (!got) begin
        tests_failed++; $display("FAIL rand%0d_timeout got=no_valid exp=valid", it);
      end else begin
        tests_run++;
        if (vin !== expv) begin
          tests_failed++; $display("FAIL rand%0d_result got=%0b exp=%0b", it, vin, expv);
        end
`ifndef GEOFENCE_CTRL_EARLY_EXIT_EN
        tests_run++;
        if (rel !== 7 + 22 * (d + 1)) begin
          tests_failed++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, rel, 7 + 22 * (d + 1));
        end
`endif
        tests_run++;
        if (nst !== 0) begin
          tests_failed++; $display("FAIL rand%0d_operand_stability got=%0d exp=0", it, nst);
        end
      end
    end
    ack_tied = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    X     = '0;
    Y     = '0;
    test_reset();
    test_spec_inside();
    test_spec_outside();
    test_vertex();
    test_ack_delay();
    test_reset_mid_sort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
